ia_tile_scheduler: RTL and testbench

Controller that sequences the double-buffered input-activation loader across a full GEMM job. It walks the (row-block, K-tile) iteration space twice: once on the fill side, where it tells the activation writer which buffer to fill and with which tile, and once on the drain side, where it issues `load_ia_trigger` together with `valid_row_num` and `is_last_tile`. Two buffer-state flags keep the writer from overwriting a buffer before the loader finishes draining it. The block sits between the MMA top-level control and the activation writer/loader pair.

---
 rtl/ia_tile_scheduler_if.sv | 51 +++++
 rtl/ia_tile_scheduler.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ia_tile_scheduler.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ia_tile_scheduler_if.sv
// ia_tile_scheduler_if: configuration, fill-side and drain-side signals of the
// input-activation tile scheduler. The master modport is the scheduler; the
// slave modport is its environment (MMA control, activation writer, loader).
// IA_SCHED_PERF_EN adds the two stall-counter outputs.
interface ia_tile_scheduler_if #(
  parameter int SIZE  = 16,
  parameter int CNT_W = 16
);
  localparam int RW = $clog2(SIZE);

  logic             cfg_start;
  logic [CNT_W-1:0] cfg_row_tiles;
  logic [CNT_W-1:0] cfg_k_tiles;
  logic [RW-1:0]    cfg_last_rows;
  logic             busy;
  logic             done;
  logic             fill_req;
  logic             fill_buf;
  logic [CNT_W-1:0] fill_row_tile;
  logic [CNT_W-1:0] fill_k_tile;
  logic             fill_done;
  logic             load_ia_trigger;
  logic [RW-1:0]    valid_row_num;
  logic             is_last_tile;
  logic             drain_buf;
  logic             ia_loading_done;
`ifdef IA_SCHED_PERF_EN
  logic [31:0]      perf_fill_stall;
  logic [31:0]      perf_drain_stall;
`endif

  modport master (
    input  cfg_start, cfg_row_tiles, cfg_k_tiles, cfg_last_rows,
    input  fill_done, ia_loading_done,
`ifdef IA_SCHED_PERF_EN
    output perf_fill_stall, perf_drain_stall,
`endif
    output busy, done, fill_req, fill_buf, fill_row_tile, fill_k_tile,
    output load_ia_trigger, valid_row_num, is_last_tile, drain_buf
  );

  modport slave (
    output cfg_start, cfg_row_tiles, cfg_k_tiles, cfg_last_rows,
    output fill_done, ia_loading_done,
`ifdef IA_SCHED_PERF_EN
    input  perf_fill_stall, perf_drain_stall,
`endif
    input  busy, done, fill_req, fill_buf, fill_row_tile, fill_k_tile,
    input  load_ia_trigger, valid_row_num, is_last_tile, drain_buf
  );
endinterface

// File: rtl/ia_tile_scheduler.sv
// ia_tile_scheduler: walks the (row-block, K-tile) space twice, once to tell
// the activation writer which ping-pong buffer to fill and once to trigger
// the loader that drains it. Per-buffer EMPTY/FULL/DRAINING state keeps a
// fill from overwriting a buffer that is still being drained.
// Optional feature macro: IA_SCHED_PERF_EN (fill/drain stall counters).
module ia_tile_scheduler #(
  parameter int SIZE  = 16,
  parameter int CNT_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  ia_tile_scheduler_if.master bus
);
  localparam int RW = $clog2(SIZE);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;
  typedef enum logic [1:0] {BUF_EMPTY = 2'd0, BUF_FULL = 2'd1, BUF_DRAINING = 2'd2} buf_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] row_tiles_q, row_tiles_d, k_tiles_q, k_tiles_d;
  logic [RW-1:0]    last_rows_q, last_rows_d;
  logic [CNT_W-1:0] fill_row_q, fill_row_d, fill_k_q, fill_k_d;
  logic [CNT_W-1:0] drain_row_q, drain_row_d, drain_k_q, drain_k_d;
  logic             fill_rem_q, fill_rem_d, drain_rem_q, drain_rem_d;
  logic             fill_ptr_q, fill_ptr_d, drain_ptr_q, drain_ptr_d;
  logic             drain_act_q, drain_act_d;
  buf_e             buf_q [2];
  buf_e             buf_d [2];
  logic             busy_q, busy_d, done_q, done_d, fill_req_q, fill_req_d;
  logic             fill_buf_q, fill_buf_d, trig_q, trig_d;
  logic [CNT_W-1:0] fill_row_tile_q, fill_row_tile_d, fill_k_tile_q, fill_k_tile_d;
  logic [RW-1:0]    valid_row_num_q, valid_row_num_d;
  logic             is_last_q, is_last_d, drain_buf_q, drain_buf_d;
  logic             start_ok, fill_fire, ld_fire, trig_cond;

  // Next-state for the job FSM, both iteration walks, buffer states and outputs
  always_comb begin
    state_d     = state_q;
    row_tiles_d = row_tiles_q;
    k_tiles_d   = k_tiles_q;
    last_rows_d = last_rows_q;
    fill_row_d  = fill_row_q;
    fill_k_d    = fill_k_q;
    drain_row_d = drain_row_q;
    drain_k_d   = drain_k_q;
    fill_rem_d  = fill_rem_q;
    drain_rem_d = drain_rem_q;
    fill_ptr_d  = fill_ptr_q;
    drain_ptr_d = drain_ptr_q;
    drain_act_d = drain_act_q;
    buf_d[0]    = buf_q[0];
    buf_d[1]    = buf_q[1];
    start_ok    = (state_q == S_IDLE) && bus.cfg_start;
    // fill_req_q already reflects RUN && buffer EMPTY && tiles remaining
    fill_fire   = fill_req_q && bus.fill_done;
    ld_fire     = (state_q == S_RUN) && drain_act_q && bus.ia_loading_done;
    trig_cond   = (state_q == S_RUN) && (buf_q[drain_ptr_q] == BUF_FULL) && !drain_act_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cfg_start) begin
          row_tiles_d = bus.cfg_row_tiles;
          k_tiles_d   = bus.cfg_k_tiles;
          last_rows_d = bus.cfg_last_rows;
          fill_row_d  = {CNT_W{1'b0}};
          fill_k_d    = {CNT_W{1'b0}};
          drain_row_d = {CNT_W{1'b0}};
          drain_k_d   = {CNT_W{1'b0}};
          fill_ptr_d  = 1'b0;
          drain_ptr_d = 1'b0;
          drain_act_d = 1'b0;
          buf_d[0]    = BUF_EMPTY;
          buf_d[1]    = BUF_EMPTY;
          if ((bus.cfg_row_tiles == {CNT_W{1'b0}}) || (bus.cfg_k_tiles == {CNT_W{1'b0}})) begin
            // empty job: report completion without touching writer or loader
            fill_rem_d  = 1'b0;
            drain_rem_d = 1'b0;
            state_d     = S_DONE;
          end else begin
            fill_rem_d  = 1'b1;
            drain_rem_d = 1'b1;
            state_d     = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (fill_fire) begin
          buf_d[fill_ptr_q] = BUF_FULL;
          fill_ptr_d        = ~fill_ptr_q;
          if (fill_k_q == k_tiles_q - CNT_W'(1)) begin
            fill_k_d   = {CNT_W{1'b0}};
            fill_row_d = fill_row_q + CNT_W'(1);
            fill_rem_d = (fill_row_q != row_tiles_q - CNT_W'(1));
          end else begin
            fill_k_d = fill_k_q + CNT_W'(1);
          end
        end else begin
          fill_ptr_d = fill_ptr_q;
        end
        if (trig_cond) begin
          buf_d[drain_ptr_q] = BUF_DRAINING;
          drain_act_d        = 1'b1;
        end else if (ld_fire) begin
          buf_d[drain_ptr_q] = BUF_EMPTY;
          drain_ptr_d        = ~drain_ptr_q;
          drain_act_d        = 1'b0;
          if (drain_k_q == k_tiles_q - CNT_W'(1)) begin
            drain_k_d   = {CNT_W{1'b0}};
            drain_row_d = drain_row_q + CNT_W'(1);
            if (drain_row_q == row_tiles_q - CNT_W'(1)) begin
              drain_rem_d = 1'b0;
              state_d     = S_DONE;
            end else begin
              drain_rem_d = 1'b1;
            end
          end else begin
            drain_k_d = drain_k_q + CNT_W'(1);
          end
        end else begin
          drain_act_d = drain_act_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // outputs are computed from next-state values so they register cleanly
    busy_d          = (state_d != S_IDLE);
    done_d          = (state_d == S_DONE);
    fill_req_d      = (state_d == S_RUN) && (buf_d[fill_ptr_d] == BUF_EMPTY) && fill_rem_d;
    fill_buf_d      = fill_ptr_d;
    fill_row_tile_d = fill_row_d;
    fill_k_tile_d   = fill_k_d;
    trig_d          = trig_cond;
    if (trig_cond) begin
      valid_row_num_d = (drain_row_q == row_tiles_q - CNT_W'(1)) ? last_rows_q : {RW{1'b0}};
      is_last_d       = (drain_k_q == k_tiles_q - CNT_W'(1));
      drain_buf_d     = drain_ptr_q;
    end else begin
      valid_row_num_d = valid_row_num_q;
      is_last_d       = is_last_q;
      drain_buf_d     = drain_buf_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      row_tiles_q     <= {CNT_W{1'b0}};
      k_tiles_q       <= {CNT_W{1'b0}};
      last_rows_q     <= {RW{1'b0}};
      fill_row_q      <= {CNT_W{1'b0}};
      fill_k_q        <= {CNT_W{1'b0}};
      drain_row_q     <= {CNT_W{1'b0}};
      drain_k_q       <= {CNT_W{1'b0}};
      fill_rem_q      <= 1'b0;
      drain_rem_q     <= 1'b0;
      fill_ptr_q      <= 1'b0;
      drain_ptr_q     <= 1'b0;
      drain_act_q     <= 1'b0;
      buf_q[0]        <= BUF_EMPTY;
      buf_q[1]        <= BUF_EMPTY;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      fill_req_q      <= 1'b0;
      fill_buf_q      <= 1'b0;
      fill_row_tile_q <= {CNT_W{1'b0}};
      fill_k_tile_q   <= {CNT_W{1'b0}};
      trig_q          <= 1'b0;
      valid_row_num_q <= {RW{1'b0}};
      is_last_q       <= 1'b0;
      drain_buf_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      row_tiles_q     <= row_tiles_d;
      k_tiles_q       <= k_tiles_d;
      last_rows_q     <= last_rows_d;
      fill_row_q      <= fill_row_d;
      fill_k_q        <= fill_k_d;
      drain_row_q     <= drain_row_d;
      drain_k_q       <= drain_k_d;
      fill_rem_q      <= fill_rem_d;
      drain_rem_q     <= drain_rem_d;
      fill_ptr_q      <= fill_ptr_d;
      drain_ptr_q     <= drain_ptr_d;
      drain_act_q     <= drain_act_d;
      buf_q[0]        <= buf_d[0];
      buf_q[1]        <= buf_d[1];
      busy_q          <= busy_d;
      done_q          <= done_d;
      fill_req_q      <= fill_req_d;
      fill_buf_q      <= fill_buf_d;
      fill_row_tile_q <= fill_row_tile_d;
      fill_k_tile_q   <= fill_k_tile_d;
      trig_q          <= trig_d;
      valid_row_num_q <= valid_row_num_d;
      is_last_q       <= is_last_d;
      drain_buf_q     <= drain_buf_d;
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.fill_req        = fill_req_q;
  assign bus.fill_buf        = fill_buf_q;
  assign bus.fill_row_tile   = fill_row_tile_q;
  assign bus.fill_k_tile     = fill_k_tile_q;
  assign bus.load_ia_trigger = trig_q;
  assign bus.valid_row_num   = valid_row_num_q;
  assign bus.is_last_tile    = is_last_q;
  assign bus.drain_buf       = drain_buf_q;

`ifdef IA_SCHED_PERF_EN
  logic [31:0] perf_fill_q, perf_fill_d, perf_drain_q, perf_drain_d;

  // Saturating stall counters, cleared when a job is accepted
  always_comb begin
    perf_fill_d  = perf_fill_q;
    perf_drain_d = perf_drain_q;
    if (start_ok) begin
      perf_fill_d  = 32'd0;
      perf_drain_d = 32'd0;
    end else if (state_q == S_RUN) begin
      if (fill_rem_q && (buf_q[0] != BUF_EMPTY) && (buf_q[1] != BUF_EMPTY) &&
          (perf_fill_q != 32'hFFFF_FFFF)) begin
        perf_fill_d = perf_fill_q + 32'd1;
      end else begin
        perf_fill_d = perf_fill_q;
      end
      if (drain_rem_q && !drain_act_q && (buf_q[drain_ptr_q] != BUF_FULL) &&
          (perf_drain_q != 32'hFFFF_FFFF)) begin
        perf_drain_d = perf_drain_q + 32'd1;
      end else begin
        perf_drain_d = perf_drain_q;
      end
    end else begin
      perf_fill_d  = perf_fill_q;
      perf_drain_d = perf_drain_q;
    end
  end

  // Stall counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fill_q  <= 32'd0;
      perf_drain_q <= 32'd0;
    end else begin
      perf_fill_q  <= perf_fill_d;
      perf_drain_q <= perf_drain_d;
    end
  end

  assign bus.perf_fill_stall  = perf_fill_q;
  assign bus.perf_drain_stall = perf_drain_q;
`endif
endmodule

// File: tb/tb_ia_tile_scheduler.sv
// tb_ia_tile_scheduler: directed bench for ia_tile_scheduler with a
// latency-programmable writer and loader responder plus manual pulse drivers.
module tb_ia_tile_scheduler;
  localparam int SIZE  = 16;
  localparam int CNT_W = 16;

  logic clk;
  logic rst;
  logic wr_pl, man_fd, ld_pl, man_ld;
  logic wr_en, ld_en;
  int   wr_lat, ld_lat;
  int   n_chk = 0;
  int   n_err = 0;
  int   trig_cnt = 0;
  int   done_cnt = 0;
  int   fill_cnt = 0;
  logic        t_buf  [64];
  logic        t_last [64];
  logic [3:0]  t_vrn  [64];
  logic        f_buf  [64];
  logic [15:0] f_row  [64];
  logic [15:0] f_k    [64];

  ia_tile_scheduler_if #(.SIZE(SIZE), .CNT_W(CNT_W)) ifc ();

  assign ifc.fill_done       = wr_pl | man_fd;
  assign ifc.ia_loading_done = ld_pl | man_ld;

  ia_tile_scheduler #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_busy"},   32'(ifc.busy), 32'd0);
    chk({pfx, "_done"},   32'(ifc.done), 32'd0);
    chk({pfx, "_freq"},   32'(ifc.fill_req), 32'd0);
    chk({pfx, "_fbuf"},   32'(ifc.fill_buf), 32'd0);
    chk({pfx, "_frow"},   32'(ifc.fill_row_tile), 32'd0);
    chk({pfx, "_fk"},     32'(ifc.fill_k_tile), 32'd0);
    chk({pfx, "_trig"},   32'(ifc.load_ia_trigger), 32'd0);
    chk({pfx, "_vrn"},    32'(ifc.valid_row_num), 32'd0);
    chk({pfx, "_last"},   32'(ifc.is_last_tile), 32'd0);
    chk({pfx, "_dbuf"},   32'(ifc.drain_buf), 32'd0);
  endtask

  task automatic wait_done(input int base, input int lim, input string tag);
    int n;
    n = 0;
    while ((done_cnt == base) && (n < lim)) begin
      tick();
      n++;
    end
    chk(tag, 32'(done_cnt != base), 32'd1);
  endtask

  task automatic start_job(input int rows, input int ks, input int last);
    ifc.cfg_row_tiles = 16'(rows);
    ifc.cfg_k_tiles   = 16'(ks);
    ifc.cfg_last_rows = 4'(last);
    ifc.cfg_start     = 1'b1;
    tick();
    ifc.cfg_start     = 1'b0;
  endtask

  // Trigger and done monitor
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (ifc.load_ia_trigger) begin
        if (trig_cnt < 64) begin
          t_buf[trig_cnt]  = ifc.drain_buf;
          t_last[trig_cnt] = ifc.is_last_tile;
          t_vrn[trig_cnt]  = ifc.valid_row_num;
        end
        trig_cnt++;
      end
      if (ifc.done) done_cnt++;
    end
  end

  // Activation writer model: answers fill_req after wr_lat cycles
  initial begin : writer
    wr_pl = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_en && ifc.fill_req) begin
        if (fill_cnt < 64) begin
          f_buf[fill_cnt] = ifc.fill_buf;
          f_row[fill_cnt] = ifc.fill_row_tile;
          f_k[fill_cnt]   = ifc.fill_k_tile;
        end
        fill_cnt++;
        repeat (wr_lat - 1) @(negedge clk);
        wr_pl = 1'b1;
        @(negedge clk);
        wr_pl = 1'b0;
      end
    end
  end

  // Loader model: answers load_ia_trigger after ld_lat cycles
  initial begin : loader
    ld_pl = 1'b0;
    forever begin
      @(negedge clk);
      if (ld_en && ifc.load_ia_trigger) begin
        repeat (ld_lat - 1) @(negedge clk);
        ld_pl = 1'b1;
        @(negedge clk);
        ld_pl = 1'b0;
      end
    end
  end

  initial begin : main
    int tb0, fb0, db0, n;
    rst = 1'b1;
    man_fd = 1'b0; man_ld = 1'b0;
    wr_en = 1'b0; ld_en = 1'b0; wr_lat = 4; ld_lat = 16;
    ifc.cfg_start = 1'b0; ifc.cfg_row_tiles = 16'd0; ifc.cfg_k_tiles = 16'd0; ifc.cfg_last_rows = 4'd0;
    repeat (3) tick();
    chk_reset("rst");
    rst = 1'b0;
    tick();

    // spurious pulses while idle
    man_fd = 1'b1; man_ld = 1'b1;
    tick();
    man_fd = 1'b0; man_ld = 1'b0;
    tick();
    chk_reset("idle_spur");

    // empty job: row_tiles = 0
    tb0 = trig_cnt;
    start_job(0, 3, 0);
    chk("zero_done1", 32'(ifc.done), 32'd1);
    chk("zero_busy1", 32'(ifc.busy), 32'd1);
    chk("zero_freq",  32'(ifc.fill_req), 32'd0);
    tick();
    chk("zero_done2", 32'(ifc.done), 32'd0);
    chk("zero_busy2", 32'(ifc.busy), 32'd0);
    // empty job: k_tiles = 0
    start_job(3, 0, 0);
    chk("zerok_done", 32'(ifc.done), 32'd1);
    chk("zerok_freq", 32'(ifc.fill_req), 32'd0);
    repeat (3) tick();
    chk("zero_ntrig", 32'(trig_cnt - tb0), 32'd0);

    // main 2x3 job, writer 4 cycles, loader 16 cycles, start-while-busy ignored
    wr_en = 1'b1; ld_en = 1'b1; wr_lat = 4; ld_lat = 16;
    tb0 = trig_cnt; fb0 = fill_cnt; db0 = done_cnt;
    start_job(2, 3, 5);
    chk("main_freq1", 32'(ifc.fill_req), 32'd1);
    chk("main_busy1", 32'(ifc.busy), 32'd1);
    chk("main_fbuf1", 32'(ifc.fill_buf), 32'd0);
    start_job(7, 9, 1);
    wait_done(db0, 2000, "main_done_seen");
    repeat (3) tick();
    chk("main_ntrig", 32'(trig_cnt - tb0), 32'd6);
    chk("main_nfill", 32'(fill_cnt - fb0), 32'd6);
    chk("main_ndone", 32'(done_cnt - db0), 32'd1);
    chk("main_busy_end", 32'(ifc.busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("main_last%0d", i), 32'(t_last[tb0 + i]), 32'((i % 3) == 2));
      chk($sformatf("main_vrn%0d", i),  32'(t_vrn[tb0 + i]),  (i >= 3) ? 32'd5 : 32'd0);
      chk($sformatf("main_dbuf%0d", i), 32'(t_buf[tb0 + i]),  32'(i % 2));
      chk($sformatf("main_fbuf%0d", i), 32'(f_buf[fb0 + i]),  32'(i % 2));
      chk($sformatf("main_frow%0d", i), 32'(f_row[fb0 + i]),  32'(i / 3));
      chk($sformatf("main_fk%0d", i),   32'(f_k[fb0 + i]),    32'(i % 3));
    end

    // manual 1x3 job: cycle-exact fill/drain, coincident events, spurious pulses
    wr_en = 1'b0; ld_en = 1'b0;
    tb0 = trig_cnt;
    start_job(1, 3, 3);
    chk("man_freq0", 32'(ifc.fill_req), 32'd1);
    chk("man_fk0",   32'(ifc.fill_k_tile), 32'd0);
    man_ld = 1'b1;                    // spurious: nothing is draining
    tick();
    man_ld = 1'b0;
    chk("man_spld_freq", 32'(ifc.fill_req), 32'd1);
    chk("man_spld_fbuf", 32'(ifc.fill_buf), 32'd0);
    man_fd = 1'b1;
    tick();
    man_fd = 1'b0;
    chk("man_freq1", 32'(ifc.fill_req), 32'd1);
    chk("man_fbuf1", 32'(ifc.fill_buf), 32'd1);
    chk("man_fk1",   32'(ifc.fill_k_tile), 32'd1);
    chk("man_trig_early", 32'(ifc.load_ia_trigger), 32'd0);
    tick();
    chk("man_trig0", 32'(ifc.load_ia_trigger), 32'd1);
    chk("man_dbuf0", 32'(ifc.drain_buf), 32'd0);
    chk("man_last0", 32'(ifc.is_last_tile), 32'd0);
    chk("man_vrn0",  32'(ifc.valid_row_num), 32'd3);
    man_fd = 1'b1; man_ld = 1'b1;     // fill buf1 and free buf0 together
    tick();
    man_fd = 1'b0; man_ld = 1'b0;
    chk("man_sim_freq", 32'(ifc.fill_req), 32'd1);
    chk("man_sim_fbuf", 32'(ifc.fill_buf), 32'd0);
    chk("man_sim_fk",   32'(ifc.fill_k_tile), 32'd2);
    chk("man_sim_trig", 32'(ifc.load_ia_trigger), 32'd0);
    tick();
    chk("man_trig1", 32'(ifc.load_ia_trigger), 32'd1);
    chk("man_dbuf1", 32'(ifc.drain_buf), 32'd1);
    chk("man_last1", 32'(ifc.is_last_tile), 32'd0);
    man_fd = 1'b1;
    tick();
    man_fd = 1'b0;
    chk("man_freq_end", 32'(ifc.fill_req), 32'd0);
    man_fd = 1'b1;                    // spurious: no fill requested
    tick();
    man_fd = 1'b0;
    chk("man_spfd_freq", 32'(ifc.fill_req), 32'd0);
    chk("man_spfd_trig", 32'(ifc.load_ia_trigger), 32'd0);
    chk("man_spfd_busy", 32'(ifc.busy), 32'd1);
    man_ld = 1'b1;
    tick();
    man_ld = 1'b0;
    chk("man_gap_trig", 32'(ifc.load_ia_trigger), 32'd0);
    tick();
    chk("man_trig2", 32'(ifc.load_ia_trigger), 32'd1);
    chk("man_dbuf2", 32'(ifc.drain_buf), 32'd0);
    chk("man_last2", 32'(ifc.is_last_tile), 32'd1);
    chk("man_vrn2",  32'(ifc.valid_row_num), 32'd3);
    man_ld = 1'b1;
    tick();
    man_ld = 1'b0;
    chk("man_done1", 32'(ifc.done), 32'd1);
    chk("man_busy1", 32'(ifc.busy), 32'd1);
    tick();
    chk("man_done2", 32'(ifc.done), 32'd0);
    chk("man_busy2", 32'(ifc.busy), 32'd0);
    chk("man_ntrig", 32'(trig_cnt - tb0), 32'd3);

    // reset during the third drain, then a 1x1 job
    wr_en = 1'b1; ld_en = 1'b1; wr_lat = 4; ld_lat = 16;
    tb0 = trig_cnt;
    start_job(2, 3, 5);
    n = 0;
    while ((trig_cnt - tb0 < 3) && (n < 500)) begin
      tick();
      n++;
    end
    chk("rstjob_3trig", 32'(trig_cnt - tb0 >= 3), 32'd1);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk_reset("midrst");
    rst = 1'b0;
    repeat (20) tick();
    chk_reset("postrst");
    tb0 = trig_cnt; db0 = done_cnt;
    start_job(1, 1, 0);
    wait_done(db0, 200, "one_done_seen");
    repeat (2) tick();
    chk("one_ntrig", 32'(trig_cnt - tb0), 32'd1);
    chk("one_last",  32'(t_last[tb0]), 32'd1);
    chk("one_vrn",   32'(t_vrn[tb0]), 32'd0);
    chk("one_dbuf",  32'(t_buf[tb0]), 32'd0);
    chk("one_ndone", 32'(done_cnt - db0), 32'd1);

`ifdef IA_SCHED_PERF_EN
    // slow writer, fast loader: only the drain side stalls
    wr_lat = 40; ld_lat = 2;
    db0 = done_cnt;
    start_job(1, 4, 0);
    wait_done(db0, 2000, "perf1_done_seen");
    chk("perf1_drain_nz", 32'(ifc.perf_drain_stall != 32'd0), 32'd1);
    chk("perf1_fill_z",   ifc.perf_fill_stall, 32'd0);
    // fast writer, slow loader: the fill side stalls
    wr_lat = 1; ld_lat = 40;
    db0 = done_cnt;
    start_job(1, 4, 0);
    wait_done(db0, 2000, "perf2_done_seen");
    chk("perf2_fill_nz",  32'(ifc.perf_fill_stall != 32'd0), 32'd1);
    chk("perf2_fill_gt",  32'(ifc.perf_fill_stall > ifc.perf_drain_stall), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
